// File: rtl/fft_frame_controller.sv
// fft_frame_controller
// Frame scheduler around an in-place FFT core. Owns the shared N-point working
// memory while loading samples and unloading results, hands it to the engine
// in between, and sequences IDLE -> LOAD -> START -> RUN -> UNLOAD -> IDLE.
//
// Optional feature macro: FFT_BITREV_EN
//   defined   : sample k is written to address bitrev(k) (input order for DIT engine)
//   undefined : sample k is written to address k
//   Results are always read back in natural order.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     allows a new frame to start from IDLE
//   in_valid/in_ready/in_data  sample input stream
//   out_valid/out_ready/out_data/out_last  result output stream (out_last on index N-1)
//   start_fft                  one-cycle engine start pulse
//   fft_done                   engine completion (level or pulse)
//   mem_sel                    1 = controller owns memory, 0 = engine owns it
//   mem_we/mem_addr/mem_wdata  memory write/read port (read data 1 cycle after addr)
//   mem_rdata                  memory read data
//   busy                       high whenever not IDLE
//   frame_done                 high in the cycle of the final result transfer
module fft_frame_controller #(
    parameter int unsigned N_LOG2 = 5,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              start_fft,
    input  logic              fft_done,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [N_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_UNLOAD
    } state_t;

    // Load address for sample index c
    function automatic logic [N_LOG2-1:0] wr_addr(input logic [N_LOG2-1:0] c);
`ifdef FFT_BITREV_EN
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_LOG2); i++) begin
            r[i] = c[N_LOG2-1-i];
        end
        return r;
`else
        return c;
`endif
    endfunction

    state_t              state_q, state_d;
    logic [N_LOG2-1:0]   cnt_q, cnt_d;
    logic [N_LOG2-1:0]   rd_cnt_q, rd_cnt_d;
    logic                rd_all_q, rd_all_d;
    logic                run_first_q, run_first_d;
    logic                infl_q, infl_d;
    logic                infl_last_q, infl_last_d;
    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [DATA_W-1:0]   fifo_data_d [2];
    logic [1:0]          fifo_last_q, fifo_last_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_sel_q, mem_sel_d;
    logic                busy_q, busy_d;
    logic                start_fft_q, start_fft_d;

    logic                in_xfer;
    logic                out_xfer;
    logic                rd_issue;
    logic [1:0]          occ;

    // Handshake decodes; in_ready_q is only high in LOAD
    assign in_xfer   = in_valid && in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign out_xfer  = out_valid && out_ready;

    // Buffer occupancy after this cycle's pop, counting the read in flight;
    // accounting for the pop is what sustains one result per cycle.
    assign occ      = count_q - 2'(out_xfer) + 2'(infl_q);
    assign rd_issue = (state_q == S_UNLOAD) && !rd_all_q && (occ < 2'd2);

    assign in_ready   = in_ready_q;
    assign mem_sel    = mem_sel_q;
    assign busy       = busy_q;
    assign start_fft  = start_fft_q;
    assign mem_we     = in_xfer;
    assign mem_wdata  = in_xfer ? in_data : '0;
    assign mem_addr   = in_xfer ? wr_addr(cnt_q) : (rd_issue ? rd_cnt_q : '0);
    assign frame_done = out_xfer && out_last;

    // Next-state, counters and output buffer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_all_d    = rd_all_q;
        run_first_d = (state_q == S_START);
        infl_d      = rd_issue;
        infl_last_d = rd_issue && (rd_cnt_q == LAST_IDX);
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + 2'(infl_q) - 2'(out_xfer);

        // Read data returning from last cycle's address enters the buffer
        if (infl_q) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (out_xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + N_LOG2'(1);
            if (rd_cnt_q == LAST_IDX) begin
                rd_all_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_xfer) begin
                    cnt_d = cnt_q + N_LOG2'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // A done level left over from the previous frame is ignored
                // in the first RUN cycle.
                if (fft_done && !run_first_q) begin
                    state_d  = S_UNLOAD;
                    rd_cnt_d = '0;
                    rd_all_d = 1'b0;
                end
            end
            S_UNLOAD: begin
                if (frame_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_LOAD);
        mem_sel_d   = (state_d == S_LOAD) || (state_d == S_UNLOAD);
        busy_d      = (state_d != S_IDLE);
        start_fft_d = (state_d == S_START);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            rd_all_q    <= 1'b0;
            run_first_q <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            start_fft_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_all_q    <= rd_all_d;
            run_first_q <= run_first_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            mem_sel_q   <= mem_sel_d;
            busy_q      <= busy_d;
            start_fft_q <= start_fft_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_controller.sv
// tb_fft_frame_controller
// Scoreboard bench: each frame pushes its expected memory writes and results
// into queues; a negedge monitor pops and compares whenever the DUT writes
// memory or transfers a result. A memory + toy engine model (XOR on start)
// sits on the memory port.
`timescale 1ns/1ps
module tb_fft_frame_controller;

    localparam int unsigned N      = 32;
    localparam logic [63:0] XMASK  = 64'hA5A5_0F0F_5A5A_F0F0;
    localparam logic [63:0] JUNK   = 64'hDEAD_BEEF_FFFF_FFFF;
`ifdef FFT_BITREV_EN
    localparam logic [4:0]  S1_ADDR = 5'd16;
    localparam logic [4:0]  S6_ADDR = 5'd12;
`else
    localparam logic [4:0]  S1_ADDR = 5'd1;
    localparam logic [4:0]  S6_ADDR = 5'd6;
`endif

    logic        clk = 1'b0;
    logic        rst_n, enable, in_valid, in_ready, out_valid, out_last;
    logic        out_ready = 1'b1;
    logic        start_fft, fft_done, mem_sel, mem_we, busy, frame_done;
    logic [63:0] in_data, out_data, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic [4:0]  mem_addr;

    always #5 clk = ~clk;

    fft_frame_controller #(.N_LOG2(5), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .start_fft  (start_fft),
        .fft_done   (fft_done),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct packed { logic [4:0] addr; logic [63:0] data; } wr_t;
    typedef struct packed { logic [63:0] data; logic last; } rs_t;

    wr_t exp_wr[$];
    rs_t exp_rs[$];
    int  n_pass = 0;
    int  n_total = 0;
    int  cyc = 0;
    int  rx_cnt = 0;
    int  fd_cnt = 0;
    int  ready_mode = 0;
    logic [63:0] mem [N];

    task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [4:0] tb_addr(input int j);
        logic [4:0] v;
        v = 5'(j);
`ifdef FFT_BITREV_EN
        return {v[0], v[1], v[2], v[3], v[4]};
`else
        return v;
`endif
    endfunction

    function automatic logic [63:0] samp(input int f, input int j);
        return {32'(f) + 32'h100, 32'(j)};
    endfunction

    task automatic check_all_zero(input string name);
        logic ok;
        ok = !in_ready && !out_valid && !out_last && !start_fft && !mem_sel && !mem_we &&
             !busy && !frame_done && (out_data == '0) && (mem_wdata == '0) && (mem_addr == '0);
        check(name, ok, {52'd0, in_ready, out_valid, out_last, start_fft, mem_sel, mem_we,
                         busy, frame_done, 4'd0}, 64'd0);
    endtask

    // Memory with 1-cycle read latency; the engine XORs every word on start
    always @(posedge clk) begin
        if (start_fft) begin
            for (int i = 0; i < int'(N); i++) mem[i] <= mem[i] ^ XMASK;
        end else if (mem_sel && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Downstream readiness: always ready, or the 1,0,0,1 pattern
    initial begin
        int rphase;
        rphase = 0;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else begin
                out_ready = (rphase == 0) || (rphase == 3);
                rphase = (rphase + 1) % 4;
            end
        end
    end

    // Monitor
    initial begin
        logic        hold_v, prev_we, prev_start, prev_in_ready, b2b_pend;
        logic [63:0] hold_d;
        logic        hold_l;
        int          fd_cyc, first_cyc, idx;
        wr_t         w;
        rs_t         r;
        hold_v = 0; prev_we = 0; prev_start = 0; prev_in_ready = 0; b2b_pend = 0;
        hold_d = '0; hold_l = 0; fd_cyc = 0; first_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hold_v = 0; prev_we = 0; prev_start = 0; prev_in_ready = 0; b2b_pend = 0;
            end else begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) check("unexpected_write", 1'b0, mem_wdata, 64'd0);
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", mem_addr == w.addr, 64'(mem_addr), 64'(w.addr));
                        check("wr_data", mem_wdata == w.data, mem_wdata, w.data);
                        if (mem_wdata[31:0] == 32'd1)
                            check("addr_sample1", mem_addr == S1_ADDR, 64'(mem_addr), 64'(S1_ADDR));
                        if (mem_wdata[31:0] == 32'd6)
                            check("addr_sample6", mem_addr == S6_ADDR, 64'(mem_addr), 64'(S6_ADDR));
                    end
                end
                if (start_fft)
                    check("start_timing", prev_we && !prev_start && exp_wr.size() == 0,
                          {62'd0, prev_we, prev_start}, 64'd2);
                prev_we = mem_we;
                prev_start = start_fft;

                if (hold_v)
                    check("stall_stable", out_valid && out_data == hold_d && out_last == hold_l,
                          out_data, hold_d);
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
                hold_l = out_last;

                if (out_valid && out_ready) begin
                    if (exp_rs.size() == 0) check("unexpected_result", 1'b0, out_data, 64'd0);
                    else begin
                        idx = int'(N) - exp_rs.size();
                        r = exp_rs.pop_front();
                        check("out_data", out_data == r.data, out_data, r.data);
                        check("out_last", out_last == r.last, 64'(out_last), 64'(r.last));
                        check("frame_done", frame_done == r.last, 64'(frame_done), 64'(r.last));
                        if (idx == 0) first_cyc = cyc;
                        if (r.last && ready_mode == 0)
                            check("burst_len", cyc - first_cyc == 31, 64'(cyc - first_cyc), 64'd31);
                        rx_cnt = idx + 1;
                        if (r.last) begin
                            fd_cnt++;
                            fd_cyc = cyc;
                            b2b_pend = enable;
                        end
                    end
                end else if (frame_done) begin
                    check("spurious_frame_done", 1'b0, 64'd1, 64'd0);
                end

                if (in_ready && !prev_in_ready && b2b_pend) begin
                    check("b2b_gap", cyc - fd_cyc == 2, 64'(cyc - fd_cyc), 64'd2);
                    b2b_pend = 0;
                end
                prev_in_ready = in_ready;
            end
        end
    end

    task automatic run_frame(input int f, input bit held, input int rmode, input bit abort, input bit drop_en);
        int  j, guard, target;
        wr_t w;
        rs_t r;
        for (int k = 0; k < int'(N); k++) begin
            w.addr = tb_addr(k);
            w.data = samp(f, k);
            exp_wr.push_back(w);
            r.data = samp(f, int'(tb_addr(k))) ^ XMASK;
            r.last = (k == int'(N) - 1);
            exp_rs.push_back(r);
        end
        rx_cnt = 0;
        target = fd_cnt + 1;
        ready_mode = rmode;
        if (held) fft_done = 1'b1;

        j = 0; guard = 0;
        while (j < int'(N) && guard < 200) begin
            @(posedge clk); #1;
            in_data = samp(f, j);
            in_valid = 1'b1;
            if (in_ready) j++;
            guard++;
        end
        check("load_complete", j == int'(N), 64'(j), 64'(N));

        @(posedge clk); #1;                      // START; stray input must be ignored
        in_data = JUNK;
        check("start_pulse", start_fft && busy && !mem_sel && !in_ready, 64'(start_fft), 64'd1);
        @(posedge clk); #1;                      // first RUN cycle
        check("run1_engine_owns", !mem_sel && !start_fft && !mem_we && mem_addr == '0 && busy,
              64'(mem_sel), 64'd0);
        if (drop_en) enable = 1'b0;
        @(posedge clk); #1;                      // second RUN cycle
        check("run2_no_early_exit", !mem_sel && busy, 64'(mem_sel), 64'd0);
        if (held) begin
            @(posedge clk); #1;
            check("held_done_exit", mem_sel && busy && !in_ready, 64'(mem_sel), 64'd1);
        end else begin
            repeat (2) @(posedge clk);
            #1;
            check("run_waits_done", !mem_sel, 64'(mem_sel), 64'd0);
            fft_done = 1'b1;
            @(posedge clk); #1;
            fft_done = 1'b0;
            check("pulse_done_exit", mem_sel, 64'(mem_sel), 64'd1);
        end

        guard = 0;
        while (guard < 400) begin
            @(posedge clk); #1;
            guard++;
            if (abort ? (rx_cnt >= 10) : (fd_cnt == target)) break;
        end
        check("unload_progress", guard < 400, 64'(guard), 64'd400);
        fft_done = 1'b0;

        if (abort) begin
            check("idx10_present", exp_rs.size() > 0 && out_valid &&
                  out_data == (exp_rs.size() > 0 ? exp_rs[0].data : 64'd0), out_data,
                  exp_rs.size() > 0 ? exp_rs[0].data : 64'd0);
            rst_n = 1'b0;
            #1;
            check_all_zero("abort_outputs");
            exp_rs.delete();
            exp_wr.delete();
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; fft_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_without_enable", !busy && !in_ready, 64'(busy), 64'd0);
        enable = 1'b1;

        run_frame(0, 1'b1, 0, 1'b0, 1'b0);   // done level held, full-rate unload
        run_frame(1, 1'b0, 1, 1'b0, 1'b0);   // done pulse, backpressure 1,0,0,1
        run_frame(2, 1'b0, 0, 1'b1, 1'b0);   // reset at result index 10
        run_frame(3, 1'b0, 0, 1'b0, 1'b1);   // enable dropped during RUN

        in_valid = 1'b1;
        in_data = JUNK;
        repeat (3) begin
            @(posedge clk); #1;
            check("stay_idle", !busy && !in_ready && !mem_sel && !mem_we, 64'(busy), 64'd0);
        end
        in_valid = 1'b0;
        check("queues_drained", exp_wr.size() == 0 && exp_rs.size() == 0,
              64'(exp_wr.size() + exp_rs.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
